alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance (operands a/b, 2-bit alucontrol, result, zero) between two requesters, e.g. the main datapath and an address/branch helper unit.
- Round-robin arbitration over valid/ready request channels.
- ALU operands are driven from registers, and the ALU result and zero flag are captured into a response register.
- Each operation is returned only to the requester that issued it.

Parameters:
- XLEN, 32, operand/result width; must match the shared ALU.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a, req0_b  input  XLEN  requester 0 operands
- req0_ctrl  input  2  requester 0 alucontrol (00 add, 01 sub, 10 and, 11 or)
- rsp0_valid  output  1  response for requester 0 valid
- rsp0_ready  input  1  requester 0 takes response
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, rsp1_valid, rsp1_ready  same as above, requester 1
- rsp_result  output  XLEN  registered ALU result (shared; qualified by rspN_valid)
- rsp_zero  output  1  registered ALU zero flag
- alu_a, alu_b  output  XLEN  to shared ALU a/b
- alu_control  output  2  to shared ALU alucontrol
- alu_result  input  XLEN  from shared ALU result
- alu_zero  input  1  from shared ALU zero

Behaviour:
- State machine: IDLE -> EXEC -> RESP -> IDLE. Encoding is free; the states are IDLE, EXEC and RESP.
- IDLE, arbitration:
  - reqN_ready is asserted combinationally only for the selected requester and only in IDLE. Never both readies high.
  - Only one valid: grant it.
  - Both valid: grant the requester not equal to last_grant.
  - Neither valid: stay IDLE.
- IDLE, on handshake (reqN_valid & reqN_ready):
  - latch reqN_a/b/ctrl into op_a/op_b/op_ctrl;
  - set owner=N and last_grant=N;
  - go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_control = op registers. They are driven from these registers in all states and are stable from EXEC through RESP.
  - At end of cycle, capture alu_result -> rsp_result and alu_zero -> rsp_zero; go to RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid is 0.
  - Hold valid, rsp_result and rsp_zero stable until rsp<owner>_ready=1, then go to IDLE.
  - No new request is accepted in RESP or EXEC.
- Latency: handshake in cycle N -> rspN_valid first high in cycle N+2. Minimum initiation interval is 3 cycles (response taken the cycle it appears).
- Requester inputs are sampled only on the handshake cycle. Later changes to a/b/ctrl or dropping valid have no effect on the operation in flight.
- Ready to a requester whose valid is low is don't-care, but it must be 0 in EXEC and RESP.
- Response back-pressure: stalls indefinitely in RESP; the other requester waits, with no timeout.
- Reset values (synchronous, takes priority over everything, including mid-EXEC/RESP):
  - state=IDLE; op_a, op_b, op_ctrl = 0 (so alu_a=alu_b=0, alu_control=00);
  - rsp_result=0, rsp_zero=0, rsp0_valid=rsp1_valid=0;
  - owner=0, last_grant=1 (requester 0 wins the first tie).
  - An operation in flight at reset is discarded; no response is issued.
- Width rules: no arithmetic inside the block; the ALU result passes through unmodified at XLEN bits, and overflow/carry are not tracked.

Optional Feature:
- ALU_ARB_PERF_EN defined:
  - adds outputs grant_cnt0 and grant_cnt1 (16-bit each, reset 0);
  - a counter increments by 1 on each accepted request of its requester and saturates at 16'hFFFF;
  - both counters clear on reset only.
- ALU_ARB_PERF_EN undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Reset, single add: reset high 2 cycles, then req0 a=5 b=7 ctrl=00 -> req0_ready=1 on the first cycle, rsp0_valid 2 cycles later, rsp_result=12, rsp_zero=0; rsp1_valid stays 0.
- Sub to zero: req1 a=0x1234 b=0x1234 ctrl=01, with the ALU computing a+~b -> rsp_result equals the ALU output bit-exactly, rsp_zero equals alu_zero. Bench uses a reference ALU model.
- Tie round-robin: both valid continuously for 4 ops -> grant order 0,1,0,1, each response routed to the matching rspN_valid, never two readies in one cycle.
- Back-pressure: rsp0_ready low for 5 cycles -> rsp0_valid, rsp_result and alu_a/b stay constant. Meanwhile req1_valid high gets no ready; req1 is granted the cycle after rsp0_ready rises.
- Reset in EXEC: assert reset during EXEC -> next cycle state IDLE, all rsp valids 0, alu_a=0; the following tie is granted to requester 0.
- ALU_ARB_PERF_EN build: 3 req0 ops and 1 req1 op -> grant_cnt0=3, grant_cnt1=1. Preload the counter near saturation via force -> holds at 0xFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// Optional grant counters are enabled with ALU_ARB_PERF_EN.
//
// state | meaning
// IDLE  | arbitrate, accept one request and latch its operands
// EXEC  | op registers drive the ALU, result/zero captured at end of cycle
// RESP  | response held for the owner until it takes it
module alu_share_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [1:0]      req0_ctrl,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [1:0]      req1_ctrl,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,

    output logic [XLEN-1:0] rsp_result,
    output logic            rsp_zero,

    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [1:0]      alu_control,
    input  logic [XLEN-1:0] alu_result,
    input  logic            alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [15:0]     grant_cnt0,
    output logic [15:0]     grant_cnt1
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] op_a_q;
    logic [XLEN-1:0] op_b_q;
    logic [1:0]      op_ctrl_q;
    logic            owner_q;
    logic            last_grant_q;
    logic [XLEN-1:0] rsp_result_q;
    logic            rsp_zero_q;
    logic            rsp0_valid_q;
    logic            rsp1_valid_q;

    logic            gnt0;
    logic            gnt1;
    logic            owner_taken;

    // A grant is only ever given to a valid requester, so a grant is a handshake.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_IDLE) begin
            if (req0_valid && req1_valid) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = req0_valid;
                gnt1 = req1_valid;
            end
        end
    end

    assign owner_taken = owner_q ? rsp1_ready : rsp0_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_ctrl_q    <= 2'b00;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt0 || gnt1) begin
                        op_a_q       <= gnt1 ? req1_a    : req0_a;
                        op_b_q       <= gnt1 ? req1_b    : req0_b;
                        op_ctrl_q    <= gnt1 ? req1_ctrl : req0_ctrl;
                        owner_q      <= gnt1;
                        last_grant_q <= gnt1;
                        state_q      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_zero_q   <= alu_zero;
                    rsp0_valid_q <= ~owner_q;
                    rsp1_valid_q <= owner_q;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (owner_taken) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp0_valid_q <= 1'b0;
                    rsp1_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req0_ready  = gnt0;
    assign req1_ready  = gnt1;
    assign rsp0_valid  = rsp0_valid_q;
    assign rsp1_valid  = rsp1_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign alu_a       = op_a_q;
    assign alu_b       = op_b_q;
    assign alu_control = op_ctrl_q;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] grant_cnt0_q;
    logic [15:0] grant_cnt0_d;
    logic [15:0] grant_cnt1_q;
    logic [15:0] grant_cnt1_d;

    // Saturating: a full counter simply stops.
    always_comb begin
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        if (gnt0 && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_d = grant_cnt0_q + 16'd1;
        if (gnt1 && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_d = grant_cnt1_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0_q <= 16'd0;
            grant_cnt1_q <= 16'd0;
        end else begin
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model checked every cycle plus directed scenarios.
// Build with ALU_ARB_PERF_EN defined to also cover the grant counters.
module tb_alu_share_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic [XLEN-1:0] req0_a, req0_b;
    logic [1:0]      req0_ctrl;
    logic            req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] req1_a, req1_b;
    logic [1:0]      req1_ctrl;
    logic [XLEN-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic            rsp_zero, alu_zero;
    logic [1:0]      alu_control;
`ifdef ALU_ARB_PERF_EN
    logic [15:0]     grant_cnt0, grant_cnt1;
`endif

    // sub_plain selects an ALU whose subtract is a+~b, to show bit-exact passthrough
    bit sub_plain = 1'b0;

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] c, input bit plain);
        case (c)
            2'b00:   return a + b;
            2'b01:   return plain ? (a + ~b) : (a - b);
            2'b10:   return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_control, sub_plain);
    assign alu_zero   = (alu_result == 32'd0);

    alu_share_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero)
`ifdef ALU_ARB_PERF_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: at most one operation in flight, tracked by its age in cycles
    bit          m_init = 1'b0;
    bit          m_busy, m_owner, m_last;
    int          m_age;
    logic [31:0] m_opa, m_opb, m_res;
    logic [1:0]  m_opc;
    logic        m_zero;
    int          m_cnt0, m_cnt1;
    bit          ce0, ce1;

    always @(negedge clk) begin
        ce0 = 1'b0;
        ce1 = 1'b0;
        if (m_init) begin
            if (!m_busy) begin
                if (req0_valid && req1_valid) begin
                    ce0 = m_last;
                    ce1 = !m_last;
                end else begin
                    ce0 = req0_valid;
                    ce1 = req1_valid;
                end
            end
            check("req0_ready", req0_ready, ce0);
            check("req1_ready", req1_ready, ce1);
            check("rsp0_valid", rsp0_valid, m_busy && m_age >= 2 && !m_owner);
            check("rsp1_valid", rsp1_valid, m_busy && m_age >= 2 && m_owner);
            check("alu_a", alu_a, m_opa);
            check("alu_b", alu_b, m_opb);
            check("alu_control", alu_control, m_opc);
            if (m_busy && m_age >= 2) begin
                check("rsp_result", rsp_result, m_res);
                check("rsp_zero", rsp_zero, m_zero);
            end
`ifdef ALU_ARB_PERF_EN
            check("grant_cnt0", grant_cnt0, m_cnt0);
            check("grant_cnt1", grant_cnt1, m_cnt1);
`endif
        end
        // advance the model to what the coming rising edge produces
        if (reset) begin
            m_init = 1'b1; m_busy = 1'b0; m_owner = 1'b0; m_last = 1'b1; m_age = 0;
            m_opa = 0; m_opb = 0; m_opc = 0; m_res = 0; m_zero = 1'b0;
            m_cnt0 = 0; m_cnt1 = 0;
        end else if (m_init) begin
            if (!m_busy) begin
                if (ce0 || ce1) begin
                    m_busy  = 1'b1;
                    m_owner = ce1;
                    m_last  = ce1;
                    m_age   = 1;
                    m_opa   = ce1 ? req1_a : req0_a;
                    m_opb   = ce1 ? req1_b : req0_b;
                    m_opc   = ce1 ? req1_ctrl : req0_ctrl;
                    if (ce0 && m_cnt0 < 65535) m_cnt0++;
                    if (ce1 && m_cnt1 < 65535) m_cnt1++;
                end
            end else if (m_age == 1) begin
                m_res  = alu_fn(m_opa, m_opb, m_opc, sub_plain);
                m_zero = (m_res == 32'd0);
                m_age  = 2;
            end else if (m_owner ? rsp1_ready : rsp0_ready) begin
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for its grant and then its response (response ready left to caller)
    task automatic run_op(input bit who, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] c, output logic [31:0] res, output logic z);
        int n;
        step();
        if (who) begin req1_valid = 1; req1_a = a; req1_b = b; req1_ctrl = c; end
        else     begin req0_valid = 1; req0_a = a; req0_b = b; req0_ctrl = c; end
        n = 0;
        @(negedge clk);
        while (!(who ? req1_ready : req0_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("grant_timeout", n < 20, 1);
        step();
        req0_valid = 0;
        req1_valid = 0;
        n = 0;
        @(negedge clk);
        while (!(who ? rsp1_valid : rsp0_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rsp_timeout", n < 20, 1);
        check("rsp_latency", n, 1);
        res = rsp_result;
        z   = rsp_zero;
    endtask

    logic [31:0] r, held_res, held_a;
    logic        z;
    int          gq[$];
    int          n;

    initial begin
        reset = 1; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        req0_a = 0; req0_b = 0; req0_ctrl = 0; req1_a = 0; req1_b = 0; req1_ctrl = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_zero", rsp_zero, 0);

        run_op(0, 32'd5, 32'd7, 2'b00, r, z);
        check("add_result", r, 32'd12);
        check("add_zero", z, 0);
        check("add_rsp1_idle", rsp1_valid, 0);

        sub_plain = 1;
        run_op(1, 32'h1234, 32'h1234, 2'b01, r, z);
        check("subplain_result", r, 32'hFFFF_FFFF);
        check("subplain_zero", z, 0);
        step();
        sub_plain = 0;
        run_op(1, 32'h1234, 32'h1234, 2'b01, r, z);
        check("sub_result", r, 32'd0);
        check("sub_zero", z, 1);

        // tie: both valid continuously, last grant was requester 1
        step();
        req0_valid = 1; req1_valid = 1;
        req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
        gq.delete();
        n = 0;
        while (gq.size() < 4 && n < 60) begin
            @(negedge clk);
            check("two_readies", req0_ready && req1_ready, 0);
            if (req0_ready) gq.push_back(0);
            if (req1_ready) gq.push_back(1);
            step();
            req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
            n++;
        end
        req0_valid = 0; req1_valid = 0;
        check("tie_count", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) check("tie_order", gq[i], i % 2);
        repeat (3) step();

        // back-pressure on requester 0 while requester 1 waits
        rsp0_ready = 0;
        run_op(0, 32'hA5A5_0000, 32'h0000_5A5A, 2'b11, r, z);
        check("bp_result", r, 32'hA5A5_5A5A);
        held_res = rsp_result;
        held_a   = alu_a;
        step();
        req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_ctrl = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid_hold", rsp0_valid, 1);
            check("bp_result_hold", rsp_result, held_res);
            check("bp_alu_a_hold", alu_a, held_a);
            check("bp_req1_blocked", req1_ready, 0);
            step();
        end
        rsp0_ready = 1;
        @(negedge clk);
        check("bp_release_valid", rsp0_valid, 1);
        check("bp_release_req1", req1_ready, 0);
        step();
        @(negedge clk);
        check("bp_req1_granted", req1_ready, 1);
        step();
        req1_valid = 0;
        repeat (3) step();

        // reset while an operation is in EXEC
        req1_valid = 1; req1_a = 32'd9; req1_b = 32'd3; req1_ctrl = 2'b00;
        @(negedge clk);
        check("rexec_grant", req1_ready, 1);
        step();
        req1_valid = 0;
        reset = 1;
        step();
        reset = 0;
        req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        check("rexec_rsp0", rsp0_valid, 0);
        check("rexec_rsp1", rsp1_valid, 0);
        check("rexec_alu_a", alu_a, 0);
        check("rexec_tie0", req0_ready, 1);
        check("rexec_tie1", req1_ready, 0);
        step();
        req0_valid = 0; req1_valid = 0;
        repeat (3) step();

        // randomized traffic, including random back-pressure and occasional reset
        for (int i = 0; i < 1500; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            req0_a = $urandom; req0_b = ($urandom_range(0, 3) == 0) ? req0_a : $urandom;
            req1_a = $urandom; req1_b = ($urandom_range(0, 3) == 0) ? req1_a : $urandom;
            req0_ctrl = 2'($urandom_range(0, 3));
            req1_ctrl = 2'($urandom_range(0, 3));
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        reset = 0; req0_valid = 0; req1_valid = 0; rsp0_ready = 1; rsp1_ready = 1;
        repeat (4) step();

`ifdef ALU_ARB_PERF_EN
        reset = 1;
        step();
        reset = 0;
        run_op(0, 1, 2, 2'b00, r, z);
        run_op(0, 3, 4, 2'b00, r, z);
        run_op(0, 5, 6, 2'b00, r, z);
        run_op(1, 7, 8, 2'b00, r, z);
        check("perf_cnt0", grant_cnt0, 3);
        check("perf_cnt1", grant_cnt1, 1);
        step();
        force dut.grant_cnt0_q = 16'hFFFE;
        m_cnt0 = 16'hFFFE;
        #1 release dut.grant_cnt0_q;
        for (int i = 0; i < 3; i++) run_op(0, i, i, 2'b10, r, z);
        check("perf_sat", grant_cnt0, 16'hFFFF);
        check("perf_cnt1_keep", grant_cnt1, 1);
`endif

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
